// File: rtl/klein_80_sched_if.sv
// rtl/klein_80_sched_if.sv - requester, response and core-side signal bundle for klein_80_sched
interface klein_80_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [0:63] req0_data;
    logic [0:79] req0_key;
    logic        req1_valid;
    logic        req1_ready;
    logic [0:63] req1_data;
    logic [0:79] req1_key;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:63] rsp_data;
    logic        rsp_id;
    logic        rsp_err;

    logic        core_start;
    logic [0:63] core_inp;
    logic [0:79] core_key;
    logic        core_ready;
    logic [0:63] core_out;

    modport slave (
        input  req0_valid, req0_data, req0_key,
        output req0_ready,
        input  req1_valid, req1_data, req1_key,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready,
        output core_start, core_inp, core_key,
        input  core_ready, core_out
    );

    modport master (
        output req0_valid, req0_data, req0_key,
        input  req0_ready,
        output req1_valid, req1_data, req1_key,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready,
        input  core_start, core_inp, core_key,
        output core_ready, core_out
    );
endinterface

// File: rtl/klein_80_sched.sv
// rtl/klein_80_sched.sv - two-requester KLEIN-80 core scheduler with round timeout
// Define KLEIN_SCHED_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module klein_80_sched #(
    parameter int ROUND_TIMEOUT = 20
) (
    input  logic                   ck,
    input  logic                   rst,
    klein_80_sched_if.slave        bus,
    output logic                   busy
);
    localparam int CW = $clog2(ROUND_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [0:63]   r_data;
    logic [0:79]   r_key;
    logic          r_id;
    logic [0:63]   r_rsp_data;
    logic          r_rsp_err;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_can_grant;
    logic [CW-1:0] w_cnt_inc;
    logic          w_expired;

`ifdef KLEIN_SCHED_RR_EN
    logic r_prio;

    assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | ~r_prio);
    assign w_gnt1 = bus.req1_valid & (~bus.req0_valid |  r_prio);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_can_grant & (w_gnt0 | w_gnt1)) begin
            r_prio <= w_gnt0;
        end
    end
`else
    assign w_gnt0 = bus.req0_valid;
    assign w_gnt1 = bus.req1_valid & ~bus.req0_valid;
`endif

    // Gated by rst so no handshake completes while the block is being reset.
    assign w_can_grant    = (r_state == IDLE) & ~rst;
    assign bus.req0_ready = w_can_grant & w_gnt0;
    assign bus.req1_ready = w_can_grant & w_gnt1;

    // r_cnt + 1 is the current RUN cycle number; aborting on cycle ROUND_TIMEOUT-1
    // puts DONE exactly ROUND_TIMEOUT cycles after LOAD.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_expired = (w_cnt_inc == CW'(ROUND_TIMEOUT - 1));

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_key      <= '0;
            r_id       <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_data  <= w_gnt1 ? bus.req1_data : bus.req0_data;
                        r_key   <= w_gnt1 ? bus.req1_key  : bus.req0_key;
                        r_id    <= w_gnt1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.core_ready) begin
                        r_rsp_data <= bus.core_out;
                        r_rsp_err  <= 1'b0;
                        r_state    <= DONE;
                    end else if (w_expired) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.core_start = (r_state == LOAD);
    assign bus.core_inp   = r_data;
    assign bus.core_key   = r_key;
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_err    = r_rsp_err;
    assign busy           = (r_state != IDLE);
endmodule
